// File: rtl/dense_pkg.sv
// dense_pkg: shared types and helpers for the time-multiplexed dense layer.
//   act_mode_t : activation selector (mode 3 decodes as relu)
//   state_t    : layer sequencer states
//   ceil_div() : integer ceiling division used for the lane-group count
//   saturate() : clamp a wide signed value to a w-bit signed range
package dense_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2
  } act_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// dense_mac_lane: one shared MAC lane of the dense layer.
// Holds a registered accumulator that is cleared, fed weight*input
// products, and finally the bias; its combinational output is the
// scaled, saturated and activated neuron value read during FINAL.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : clear accumulator (first FETCH cycle of a group)
//   acc_en_i     : accumulate this cycle
//   bias_i       : the current ROM word is the bias, not a weight
//   x_i          : selected input node value
//   w_i          : this lane's ROM word (weight or bias)
//   act_mode_i   : activation selector
//   act_o        : activated, saturated result of the accumulator
module dense_mac_lane
  import dense_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int ACC_W = 28,
  parameter int FRAC  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    acc_en_i,
  input  logic                    bias_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] w_i,
  input  logic [1:0]              act_mode_i,
  output logic signed [WIDTH-1:0] act_o
);

  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   addend;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [63:0]        sat_wide;
  logic signed [WIDTH-1:0]   sat;

  always_comb begin
    prod = (2*WIDTH)'(x_i) * (2*WIDTH)'(w_i);
    // The bias is pre-scaled so it lines up with the fixed-point products.
    if (bias_i) addend = ACC_W'(w_i) <<< FRAC;
    else        addend = ACC_W'(prod);
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (acc_en_i) acc_d = acc_q + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // FINAL stage: rescale, saturate, activate
  always_comb begin
    shifted  = acc_q >>> FRAC;
    sat_wide = saturate(64'(shifted), WIDTH);
    sat      = WIDTH'(sat_wide);
    case (act_mode_t'(act_mode_i))
      ACT_NONE:  act_o = sat;
      // Arithmetic shift floors toward minus infinity.
      ACT_LEAKY: act_o = sat[WIDTH-1] ? (sat >>> 3) : sat;
      default:   act_o = sat[WIDTH-1] ? '0 : sat;
    endcase
  end

endmodule

// File: rtl/dense_layer_tm.sv
// dense_layer_tm: time-multiplexed fully-connected layer.
// OUT_N neurons over IN_N inputs are evaluated LANES at a time. Each lane
// group streams IN_N weight words plus one bias word from an external
// synchronous ROM (one-cycle read latency), then writes its activated
// results into out_vec.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request an evaluation (accepted only when ready)
//   ready      : high in IDLE
//   act_mode   : activation, latched on start acceptance
//   in_vec     : packed signed inputs, latched on start acceptance
//   rom_addr   : ROM word address
//   rom_data   : ROM word, one cycle after rom_addr, packed per lane
//   out_vec    : packed signed activated outputs
//   out_valid  : out_vec holds a complete result
//   done       : one-cycle completion pulse
module dense_layer_tm
  import dense_pkg::*;
#(
  parameter  int IN_N  = 200,
  parameter  int OUT_N = 18,
  parameter  int WIDTH = 10,
  parameter  int LANES = 2,
  parameter  int FRAC  = 0,
  parameter  int ACC_W = 2*WIDTH + $clog2(IN_N+1),
  localparam int G     = ceil_div(OUT_N, LANES),
  localparam int AW    = $clog2(G*(IN_N+1))
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   ready,
  input  logic [1:0]             act_mode,
  input  logic [IN_N*WIDTH-1:0]  in_vec,
  output logic [AW-1:0]          rom_addr,
  input  logic [LANES*WIDTH-1:0] rom_data,
  output logic [OUT_N*WIDTH-1:0] out_vec,
  output logic                   out_valid,
  output logic                   done
);

  localparam int KW = $clog2(IN_N+1);
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   base_q, base_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      act_q;
  logic            accept;

  logic signed [WIDTH-1:0] x_q   [IN_N];
  logic signed [WIDTH-1:0] out_q [OUT_N];
  logic signed [WIDTH-1:0] act   [LANES];

  logic            lane_clr;
  logic            lane_acc;
  logic            lane_bias;
  logic [KW-1:0]   km1;
  logic signed [WIDTH-1:0] x_sel;

  // Sequencer
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    k_d         = k_q;
    base_d      = base_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept      = 1'b1;
          out_valid_d = 1'b0;
          g_d         = '0;
          k_d         = '0;
          base_d      = '0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (k_q == KW'(IN_N)) begin
          k_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DRAIN: state_d = ST_FINAL;
      ST_FINAL: begin
        if (g_q == GW'(G-1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          g_d     = g_q + GW'(1);
          base_d  = base_q + AW'(IN_N+1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ROM data lags the address by one cycle, so FETCH step k consumes the
  // word for input k-1 and the bias word lands in DRAIN.
  always_comb begin
    lane_clr  = (state_q == ST_FETCH) && (k_q == '0);
    lane_acc  = ((state_q == ST_FETCH) && (k_q != '0)) || (state_q == ST_DRAIN);
    lane_bias = (state_q == ST_DRAIN);
    km1       = k_q - KW'(1);
    x_sel     = '0;
    for (int i = 0; i < IN_N; i++) begin
      if (km1 == KW'(i)) x_sel = x_q[i];
    end
    rom_addr = (state_q == ST_FETCH) ? (base_q + AW'(k_q)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      k_q         <= '0;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      act_q       <= '0;
      for (int i = 0; i < IN_N; i++)  x_q[i]   <= '0;
      for (int j = 0; j < OUT_N; j++) out_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      k_q         <= k_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        act_q <= act_mode;
        for (int i = 0; i < IN_N; i++) x_q[i] <= in_vec[i*WIDTH +: WIDTH];
      end
      // Lanes mapping past OUT_N match no output slot and are dropped.
      if (state_q == ST_FINAL) begin
        for (int j = 0; j < OUT_N; j++) begin
          for (int l = 0; l < LANES; l++) begin
            if (int'(g_q) * LANES + l == j) out_q[j] <= act[l];
          end
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dense_mac_lane #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W),
      .FRAC  (FRAC)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (lane_clr),
      .acc_en_i   (lane_acc),
      .bias_i     (lane_bias),
      .x_i        (x_sel),
      .w_i        (rom_data[l*WIDTH +: WIDTH]),
      .act_mode_i (act_q),
      .act_o      (act[l])
    );
  end

  for (genvar j = 0; j < OUT_N; j++) begin : g_out
    assign out_vec[j*WIDTH +: WIDTH] = out_q[j];
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;

endmodule
